comparator_sequencer: RTL



---
 rtl/comparator_sequencer_pkg.sv | 24 ++
 rtl/cmp_sync2.sv | 33 +++
 rtl/comparator_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/comparator_sequencer_pkg.sv
// Shared definitions for the StrongARM comparator sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package comparator_sequencer_pkg;

   // Sequencer states: idle, precharge, evaluate, result held for consumer
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_EVAL = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Default timing and voting parameters
   localparam int DEF_RESET_CYCLES = 2;
   localparam int DEF_EVAL_CYCLES  = 4;
   localparam int DEF_VOTES        = 3;
   localparam int DEF_MAX_INVALID  = 4;

   // Synchronised {outp,outn} decision encodings; anything else is unresolved
   localparam logic [1:0] VALID_ONE  = 2'b10;
   localparam logic [1:0] VALID_ZERO = 2'b01;

endpackage

// File: rtl/cmp_sync2.sv
// Two-flop synchroniser for the comparator's differential outputs.
// Latency: 2 cycles from a settled input to sync_dat.
// Backpressure: none; samples every cycle, cleared asynchronously by RST.
module cmp_sync2 (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] async_dat,
   output logic [1:0] sync_dat
);

   logic [1:0] meta_q, meta_d;
   logic [1:0] sync_q, sync_d;

   // Shift the asynchronous pair through two stages
   always_comb begin
      meta_d = async_dat;
      sync_d = meta_q;
   end

   // Synchroniser flops, cleared so a stale decision cannot leak past reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         meta_q <= 2'b00;
         sync_q <= 2'b00;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_dat = sync_q;

endmodule

// File: rtl/comparator_sequencer.sv
// Precharge/evaluate sequencer with invalid-sample rejection and majority vote.
// Latency: VOTES*(RESET_CYCLES+EVAL_CYCLES)+1 cycles from start, +1 window per invalid sample.
// Backpressure: result registers hold while dout_ready=0; start is ignored outside IDLE.
module comparator_sequencer
   import comparator_sequencer_pkg::*;
#(
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int EVAL_CYCLES  = DEF_EVAL_CYCLES,
   parameter int VOTES        = DEF_VOTES,
   parameter int MAX_INVALID  = DEF_MAX_INVALID
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       start,
   output logic                       busy,
   output logic                       cmp_clk,
   input  logic                       cmp_outp,
   input  logic                       cmp_outn,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       dout_bit,
   output logic [$clog2(VOTES+1)-1:0] dout_ones,
   output logic                       dout_err
);

   localparam int VW     = $clog2(VOTES + 1);
   localparam int IW     = $clog2(MAX_INVALID + 1);
   localparam int PH_MAX = (RESET_CYCLES > EVAL_CYCLES) ? RESET_CYCLES : EVAL_CYCLES;
   localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PW-1:0] PRE_LAST  = PW'(RESET_CYCLES - 1);
   localparam logic [PW-1:0] EVAL_LAST = PW'(EVAL_CYCLES - 1);
   localparam logic [VW-1:0] VOTES_N   = VW'(VOTES);
   localparam logic [VW-1:0] HALF      = VW'(VOTES / 2);
   localparam logic [IW-1:0] INV_LIMIT = IW'(MAX_INVALID);

   state_e          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [VW-1:0]   votes_q, votes_d;
   logic [VW-1:0]   ones_q, ones_d;
   logic [IW-1:0]   inv_q, inv_d;
   logic            cmp_clk_q, cmp_clk_d;
   logic            dout_valid_q, dout_valid_d;
   logic            dout_bit_q, dout_bit_d;
   logic [VW-1:0]   dout_ones_q, dout_ones_d;
   logic            dout_err_q, dout_err_d;
   logic [1:0]      sync_dat;

   cmp_sync2 u_sync (
      .CLK       (CLK),
      .RST       (RST),
      .async_dat ({cmp_outp, cmp_outn}),
      .sync_dat  (sync_dat)
   );

   // Next-state, tally and result computation; outputs registered from next state
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      votes_d     = votes_q;
      ones_d      = ones_q;
      inv_d       = inv_q;
      dout_bit_d  = dout_bit_q;
      dout_ones_d = dout_ones_q;
      dout_err_d  = dout_err_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_PRE;
               phase_d = '0;
               votes_d = '0;
               ones_d  = '0;
               inv_d   = '0;
            end
         end

         ST_PRE: begin
            if (phase_q == PRE_LAST) begin
               state_d = ST_EVAL;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         ST_EVAL: begin
            if (phase_q == EVAL_LAST) begin
               phase_d = '0;
               // The synchroniser output has settled by the last evaluate cycle
               case (sync_dat)
                  VALID_ONE: begin
                     votes_d = votes_q + 1'b1;
                     ones_d  = ones_q + 1'b1;
                  end
                  VALID_ZERO: votes_d = votes_q + 1'b1;
                  default:    inv_d   = inv_q + 1'b1;
               endcase

               if (inv_d == INV_LIMIT) begin
                  state_d     = ST_DONE;
                  dout_err_d  = 1'b1;
                  dout_bit_d  = 1'b0;
                  dout_ones_d = ones_d;
               end else if (votes_d == VOTES_N) begin
                  state_d     = ST_DONE;
                  dout_err_d  = 1'b0;
                  dout_bit_d  = (ones_d > HALF);
                  dout_ones_d = ones_d;
               end else begin
                  state_d = ST_PRE;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end

         ST_DONE: begin
            // Result is consumed; clear it so IDLE presents all-zero outputs
            if (dout_ready) begin
               state_d     = ST_IDLE;
               dout_bit_d  = 1'b0;
               dout_ones_d = '0;
               dout_err_d  = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      cmp_clk_d    = (state_d == ST_EVAL);
      dout_valid_d = (state_d == ST_DONE);
   end

   // State, counters and output registers; reset also forces the comparator into precharge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         votes_q      <= '0;
         ones_q       <= '0;
         inv_q        <= '0;
         cmp_clk_q    <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_bit_q   <= 1'b0;
         dout_ones_q  <= '0;
         dout_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         votes_q      <= votes_d;
         ones_q       <= ones_d;
         inv_q        <= inv_d;
         cmp_clk_q    <= cmp_clk_d;
         dout_valid_q <= dout_valid_d;
         dout_bit_q   <= dout_bit_d;
         dout_ones_q  <= dout_ones_d;
         dout_err_q   <= dout_err_d;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign cmp_clk    = cmp_clk_q;
   assign dout_valid = dout_valid_q;
   assign dout_bit   = dout_bit_q;
   assign dout_ones  = dout_ones_q;
   assign dout_err   = dout_err_q;

endmodule
